// File: rtl/udp_receive_param.sv
// udp_receive_param: Ethernet/IPv4/UDP receive filter and payload extractor.
// Bytes are assembled from a GMII (8-bit) or MII (4-bit, low nibble first) bus.
// Headers are parsed one byte per byte strobe. Frames addressed to this board
// have their UDP payload streamed out on rec_en/rec_data. All other frames are
// counted in drop_cnt.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for rxdv (armed only after rxdv has been seen low)
// PREAMBLE | expecting 7 x 0x55 then 0xD5
// ETH_HEAD | 14-byte MAC header: destination MAC, ethertype 0x0800
// IP_HEAD  | 20-byte IPv4 header: version/IHL, protocol, dst IP, checksum
// IP_OPT   | skipping (IHL-5)*4 option bytes
// UDP_HEAD | 8-byte UDP header: dst port, length, capture source info
// RX_DATA  | streaming payload bytes
// RX_END   | swallowing padding/FCS until rxdv falls

module udp_receive_param #(
  parameter int          DATA_W       = 8,
  parameter logic [47:0] BOARD_MAC    = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP     = {8'd192, 8'd168, 8'd1, 8'd123},
  parameter logic [15:0] BOARD_PORT   = 16'd5000,
  parameter bit          ACCEPT_BCAST = 1'b1,
  parameter bit          CHECK_CSUM   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              eth_rxdv,
  input  logic [DATA_W-1:0] eth_rx_data,
  output logic              rec_en,
  output logic [7:0]        rec_data,
  output logic [15:0]       rec_byte_num,
  output logic              rec_pkt_done,
  output logic              rec_pkt_err,
  output logic [31:0]       src_ip,
  output logic [15:0]       src_port,
  output logic [15:0]       drop_cnt
);

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, ETH_HEAD, IP_HEAD, IP_OPT, UDP_HEAD, RX_DATA, RX_END
  } state_t;

  logic       byte_stb;
  logic [7:0] rx_byte;

  generate
    if (DATA_W == 8) begin : g_gmii
      assign byte_stb = eth_rxdv;
      assign rx_byte  = eth_rx_data;
    end else begin : g_mii
      logic       phase;
      logic [3:0] lo_nib;
      // pair nibbles low-first; the phase restarts whenever rxdv is low
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          phase  <= 1'b0;
          lo_nib <= 4'd0;
        end else if (!eth_rxdv) begin
          phase  <= 1'b0;
        end else begin
          phase <= ~phase;
          if (!phase) lo_nib <= eth_rx_data;
        end
      end
      assign byte_stb = eth_rxdv & phase;
      assign rx_byte  = {eth_rx_data, lo_nib};
    end
  endgenerate

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n, pcnt;
  logic [39:0] sh, sh_n;
  logic [15:0] csum, csum_n, csum_fold;
  logic [16:0] csum_sum;
  logic [3:0]  ihl, ihl_n;
  logic [31:0] ip_t, ip_t_n;
  logic [15:0] sport_t, sport_t_n;
  logic        acc, acc_n, armed, armed_n;
  logic        rec_en_n, done_n, err_n;
  logic [7:0]  rec_data_n;
  logic [15:0] rec_byte_num_n, src_port_n, drop_cnt_n, ulen;
  logic [31:0] src_ip_n;
  logic        hdr_drop, abort, pre;

  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 16'd0;
      sh           <= 40'd0;
      csum         <= 16'd0;
      ihl          <= 4'd0;
      ip_t         <= 32'd0;
      sport_t      <= 16'd0;
      acc          <= 1'b0;
      armed        <= 1'b0;
      rec_en       <= 1'b0;
      rec_data     <= 8'd0;
      rec_byte_num <= 16'd0;
      rec_pkt_done <= 1'b0;
      rec_pkt_err  <= 1'b0;
      src_ip       <= 32'd0;
      src_port     <= 16'd0;
      drop_cnt     <= 16'd0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      sh           <= sh_n;
      csum         <= csum_n;
      ihl          <= ihl_n;
      ip_t         <= ip_t_n;
      sport_t      <= sport_t_n;
      acc          <= acc_n;
      armed        <= armed_n;
      rec_en       <= rec_en_n;
      rec_data     <= rec_data_n;
      rec_byte_num <= rec_byte_num_n;
      rec_pkt_done <= done_n;
      rec_pkt_err  <= err_n;
      src_ip       <= src_ip_n;
      src_port     <= src_port_n;
      drop_cnt     <= drop_cnt_n;
    end
  end

  // next-state, header checks and output pulses
  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    sh_n           = sh;
    csum_n         = csum;
    ihl_n          = ihl;
    ip_t_n         = ip_t;
    sport_t_n      = sport_t;
    acc_n          = acc;
    armed_n        = armed | ~eth_rxdv;
    rec_en_n       = 1'b0;
    rec_data_n     = rec_data;
    rec_byte_num_n = rec_byte_num;
    done_n         = 1'b0;
    err_n          = 1'b0;
    src_ip_n       = src_ip;
    src_port_n     = src_port;
    drop_cnt_n     = drop_cnt;
    hdr_drop       = 1'b0;
    abort          = 1'b0;
    pre            = 1'b0;
    pcnt           = (state == IDLE) ? 16'd0 : cnt;
    ulen           = sh[23:8];
    csum_sum       = {1'b0, csum} + {1'b0, sh[7:0], rx_byte};
    csum_fold      = csum_sum[15:0] + {15'd0, csum_sum[16]};

    if (byte_stb) sh_n = {sh[31:0], rx_byte};

    if (!eth_rxdv && state != IDLE && state != RX_END) begin
      abort   = 1'b1;
      state_n = IDLE;
      cnt_n   = 16'd0;
      err_n   = (state == RX_DATA);
    end else begin
      case (state)
        IDLE: begin
          cnt_n = 16'd0;
          if (eth_rxdv && armed) begin
            state_n = PREAMBLE;
            pre     = byte_stb;
          end
        end
        PREAMBLE: pre = byte_stb;
        ETH_HEAD: if (byte_stb) begin
          cnt_n = cnt + 16'd1;
          if (cnt == 16'd5) begin
            if (!(({sh, rx_byte} == BOARD_MAC) ||
                  (ACCEPT_BCAST && ({sh, rx_byte} == 48'hFFFF_FFFF_FFFF))))
              hdr_drop = 1'b1;
          end else if (cnt == 16'd13) begin
            if ({sh[7:0], rx_byte} == 16'h0800) begin
              state_n = IP_HEAD;
              cnt_n   = 16'd0;
              csum_n  = 16'd0;
            end else begin
              hdr_drop = 1'b1;
            end
          end
        end
        IP_HEAD: if (byte_stb) begin
          cnt_n = cnt + 16'd1;
          if (cnt[0]) csum_n = csum_fold;
          if (cnt == 16'd0) begin
            ihl_n = rx_byte[3:0];
            if (rx_byte[7:4] != 4'd4 || rx_byte[3:0] < 4'd5) hdr_drop = 1'b1;
          end else if (cnt == 16'd9) begin
            if (rx_byte != 8'h11) hdr_drop = 1'b1;
          end else if (cnt == 16'd15) begin
            ip_t_n = {sh[23:0], rx_byte};
          end else if (cnt == 16'd19) begin
            if ({sh[23:0], rx_byte} != BOARD_IP ||
                (CHECK_CSUM && csum_fold != 16'hFFFF)) begin
              hdr_drop = 1'b1;
            end else begin
              state_n = (ihl == 4'd5) ? UDP_HEAD : IP_OPT;
              cnt_n   = 16'd0;
            end
          end
        end
        IP_OPT: if (byte_stb) begin
          cnt_n = cnt + 16'd1;
          if (cnt == ({10'd0, ihl, 2'b00} - 16'd21)) begin
            state_n = UDP_HEAD;
            cnt_n   = 16'd0;
          end
        end
        UDP_HEAD: if (byte_stb) begin
          cnt_n = cnt + 16'd1;
          if (cnt == 16'd1) sport_t_n = {sh[7:0], rx_byte};
          if (cnt == 16'd7) begin
            // sh now holds bytes 2..6: dst port in [39:24], length in [23:8]
            if (sh[39:24] != BOARD_PORT || ulen < 16'd8) begin
              hdr_drop = 1'b1;
            end else begin
              rec_byte_num_n = ulen - 16'd8;
              src_ip_n       = ip_t;
              src_port_n     = sport_t;
              cnt_n          = 16'd0;
              if (ulen == 16'd8) begin
                state_n = RX_END;
                acc_n   = 1'b1;
              end else begin
                state_n = RX_DATA;
              end
            end
          end
        end
        RX_DATA: if (byte_stb) begin
          rec_en_n   = 1'b1;
          rec_data_n = rx_byte;
          cnt_n      = cnt + 16'd1;
          if (cnt + 16'd1 == rec_byte_num) begin
            state_n = RX_END;
            acc_n   = 1'b1;
          end
        end
        RX_END: if (!eth_rxdv) begin
          state_n = IDLE;
          cnt_n   = 16'd0;
          done_n  = acc;
          acc_n   = 1'b0;
        end
        default: state_n = IDLE;
      endcase
    end

    if (pre) begin
      if (pcnt < 16'd7) begin
        if (rx_byte == 8'h55) cnt_n = pcnt + 16'd1;
        else                  hdr_drop = 1'b1;
      end else if (rx_byte == 8'hD5) begin
        state_n = ETH_HEAD;
        cnt_n   = 16'd0;
      end else begin
        hdr_drop = 1'b1;
      end
    end

    if (hdr_drop) begin
      state_n = RX_END;
      acc_n   = 1'b0;
      cnt_n   = 16'd0;
    end

    if ((hdr_drop || abort) && drop_cnt != 16'hFFFF) drop_cnt_n = drop_cnt + 16'd1;
  end

endmodule

// File: tb/tb_udp_receive_param.sv
// Scoreboard bench for udp_receive_param: three instances (GMII default,
// GMII without checksum enforcement, MII) driven from directed frames.
module tb_udp_receive_param;

  localparam logic [47:0] MAC = 48'h00_11_22_33_44_55;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dv8 = 1'b0, dvn = 1'b0, dv4 = 1'b0;
  logic [7:0] d8 = 8'd0, dn = 8'd0;
  logic [3:0] d4 = 4'd0;

  logic en8, done8, err8, enn, donen, errn, en4, done4, err4;
  logic [7:0] data8, datan, data4;
  logic [15:0] bn8, bnn, bn4, sp8, spn, sp4, drop8, dropn, drop4;
  logic [31:0] sip8, sipn, sip4;

  int checks = 0;
  int failures = 0;
  logic [7:0] frm[$];
  logic [9:0] q8[$], qnc[$], q4[$];

  always #5 clk = ~clk;

  udp_receive_param u8 (
    .clk(clk), .rst(rst), .eth_rxdv(dv8), .eth_rx_data(d8),
    .rec_en(en8), .rec_data(data8), .rec_byte_num(bn8), .rec_pkt_done(done8),
    .rec_pkt_err(err8), .src_ip(sip8), .src_port(sp8), .drop_cnt(drop8));

  udp_receive_param #(.CHECK_CSUM(1'b0)) unc (
    .clk(clk), .rst(rst), .eth_rxdv(dvn), .eth_rx_data(dn),
    .rec_en(enn), .rec_data(datan), .rec_byte_num(bnn), .rec_pkt_done(donen),
    .rec_pkt_err(errn), .src_ip(sipn), .src_port(spn), .drop_cnt(dropn));

  udp_receive_param #(.DATA_W(4)) u4 (
    .clk(clk), .rst(rst), .eth_rxdv(dv4), .eth_rx_data(d4),
    .rec_en(en4), .rec_data(data4), .rec_byte_num(bn4), .rec_pkt_done(done4),
    .rec_pkt_err(err4), .src_ip(sip4), .src_port(sp4), .drop_cnt(drop4));

  function automatic logic [7:0] pay(input int i);
    return 8'(i * 13 + 7);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic push(input int s, input logic [9:0] v);
    case (s)
      0: q8.push_back(v);
      1: qnc.push_back(v);
      default: q4.push_back(v);
    endcase
  endtask

  // payload bytes followed by a done (10'h100) or err (10'h200) marker
  task automatic expect_frame(input int s, input int n, input logic [9:0] tail);
    for (int i = 0; i < n; i++) push(s, {2'b00, pay(i)});
    push(s, tail);
  endtask

  task automatic pop_cmp(input int s, input logic [9:0] got);
    logic [9:0] e;
    bit have;
    have = 1'b0;
    e = 10'd0;
    case (s)
      0: if (q8.size() != 0) begin e = q8.pop_front(); have = 1'b1; end
      1: if (qnc.size() != 0) begin e = qnc.pop_front(); have = 1'b1; end
      default: if (q4.size() != 0) begin e = q4.pop_front(); have = 1'b1; end
    endcase
    checks++;
    if (!have) begin
      failures++;
      $display("FAIL evt%0d unexpected got=%h exp=none", s, got);
    end else if (e !== got) begin
      failures++;
      $display("FAIL evt%0d got=%h exp=%h", s, got, e);
    end
  endtask

  task automatic mon(input int s, input logic en, input logic [7:0] d, input logic dn_i, input logic er);
    if (en) pop_cmp(s, {2'b00, d});
    if (dn_i) pop_cmp(s, 10'h100);
    if (er) pop_cmp(s, 10'h200);
    if (dn_i || er) chk($sformatf("done_err_excl%0d", s), {31'd0, dn_i & er}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, en8, data8, done8, err8);
      mon(1, enn, datan, donen, errn);
      mon(2, en4, data4, done4, err4);
    end
  end

  task automatic build(input logic [47:0] dmac, input logic [3:0] ihl, input logic [15:0] sport,
                       input logic [15:0] dport, input logic [15:0] ulen, input int npay,
                       input bit bad_csum, input bit fcs);
    logic [7:0]  h[20];
    logic [31:0] s;
    logic [15:0] c, tl;
    frm.delete();
    repeat (7) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    for (int i = 0; i < 6; i++) frm.push_back(dmac[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(8'h02 + 8'(i));
    frm.push_back(8'h08);
    frm.push_back(8'h00);
    tl = 16'(ihl) * 16'd4 + ulen;
    h = '{{4'h4, ihl}, 8'h00, tl[15:8], tl[7:0], 8'h00, 8'h01, 8'h40, 8'h00, 8'h40, 8'h11,
          8'h00, 8'h00, 8'd192, 8'd168, 8'd1, 8'd10, 8'd192, 8'd168, 8'd1, 8'd123};
    s = 32'd0;
    for (int i = 0; i < 20; i += 2) s = s + {16'd0, h[i], h[i+1]};
    s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    c = ~s[15:0];
    if (bad_csum) c = c ^ 16'h0001;
    h[10] = c[15:8];
    h[11] = c[7:0];
    for (int i = 0; i < 20; i++) frm.push_back(h[i]);
    for (int i = 0; i < (int'(ihl) - 5) * 4; i++) frm.push_back(8'h01);
    frm.push_back(sport[15:8]); frm.push_back(sport[7:0]);
    frm.push_back(dport[15:8]); frm.push_back(dport[7:0]);
    frm.push_back(ulen[15:8]);  frm.push_back(ulen[7:0]);
    frm.push_back(8'h00);       frm.push_back(8'h00);
    for (int i = 0; i < npay; i++) frm.push_back(pay(i));
    if (fcs) begin
      frm.push_back(8'hDE); frm.push_back(8'hAD); frm.push_back(8'hBE); frm.push_back(8'hEF);
    end
  endtask

  task automatic send(input int s, input int rst_at);
    foreach (frm[i]) begin
      @(posedge clk); #1;
      if (rst_at >= 0 && i == rst_at) rst = 1'b1;
      if (rst_at >= 0 && i == rst_at + 3) rst = 1'b0;
      if (rst_at >= 0 && i == rst_at + 1) begin
        chk("rst_mid_drop", {16'd0, drop8}, 32'd0);
        chk("rst_mid_srcip", sip8, 32'd0);
        chk("rst_mid_bytenum", {16'd0, bn8}, 32'd0);
        chk("rst_mid_srcport", {16'd0, sp8}, 32'd0);
      end
      case (s)
        0: begin dv8 = 1'b1; d8 = frm[i]; end
        1: begin dvn = 1'b1; dn = frm[i]; end
        default: begin
          dv4 = 1'b1; d4 = frm[i][3:0];
          @(posedge clk); #1;
          d4 = frm[i][7:4];
        end
      endcase
    end
    @(posedge clk); #1;
    dv8 = 1'b0; dvn = 1'b0; dv4 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", {31'd0, en8}, 32'd0);
    chk("rst_data", {24'd0, data8}, 32'd0);
    chk("rst_bytenum", {16'd0, bn8}, 32'd0);
    chk("rst_done", {31'd0, done8}, 32'd0);
    chk("rst_err", {31'd0, err8}, 32'd0);
    chk("rst_srcip", sip8, 32'd0);
    chk("rst_srcport", {16'd0, sp8}, 32'd0);
    chk("rst_drop", {16'd0, drop8}, 32'd0);
    rst = 1'b0;
    idle(3);

    // GMII unicast, UDP length 30 -> 22 payload bytes
    build(MAC, 4'd5, 16'h1234, 16'd5000, 16'd30, 22, 1'b0, 1'b1);
    expect_frame(0, 22, 10'h100);
    send(0, -1);
    idle(6);
    chk("t1_bytenum", {16'd0, bn8}, 32'd22);
    chk("t1_srcip", sip8, 32'hC0A8_010A);
    chk("t1_srcport", {16'd0, sp8}, 32'h1234);
    chk("t1_drop", {16'd0, drop8}, 32'd0);
    chk("t1_q_empty", q8.size(), 32'd0);

    // same frame on the MII instance
    build(MAC, 4'd5, 16'h1234, 16'd5000, 16'd30, 22, 1'b0, 1'b1);
    expect_frame(2, 22, 10'h100);
    send(2, -1);
    idle(6);
    chk("t2_bytenum", {16'd0, bn4}, 32'd22);
    chk("t2_drop", {16'd0, drop4}, 32'd0);
    chk("t2_q_empty", q4.size(), 32'd0);

    // bad checksum: dropped with checking on, accepted with it off
    build(MAC, 4'd5, 16'h1234, 16'd5000, 16'd30, 22, 1'b1, 1'b1);
    send(0, -1);
    idle(6);
    chk("t3_drop", {16'd0, drop8}, 32'd1);
    chk("t3_q_empty", q8.size(), 32'd0);
    expect_frame(1, 22, 10'h100);
    send(1, -1);
    idle(6);
    chk("t3nc_drop", {16'd0, dropn}, 32'd0);
    chk("t3nc_bytenum", {16'd0, bnn}, 32'd22);
    chk("t3nc_q_empty", qnc.size(), 32'd0);

    // IHL=6 with 4 option bytes, zero-length payload
    build(MAC, 4'd6, 16'h4321, 16'd5000, 16'd8, 0, 1'b0, 1'b1);
    expect_frame(0, 0, 10'h100);
    send(0, -1);
    idle(6);
    chk("t4_bytenum", {16'd0, bn8}, 32'd0);
    chk("t4_srcport", {16'd0, sp8}, 32'h4321);
    chk("t4_drop", {16'd0, drop8}, 32'd1);
    chk("t4_q_empty", q8.size(), 32'd0);

    // rxdv falls after 5 of 22 payload bytes
    build(MAC, 4'd5, 16'h1234, 16'd5000, 16'd30, 5, 1'b0, 1'b0);
    expect_frame(0, 5, 10'h200);
    send(0, -1);
    idle(6);
    chk("t5_drop", {16'd0, drop8}, 32'd2);
    chk("t5_q_empty", q8.size(), 32'd0);

    // wrong port 5001 then a valid frame back-to-back
    build(MAC, 4'd5, 16'h1234, 16'd5001, 16'd30, 22, 1'b0, 1'b1);
    send(0, -1);
    build(MAC, 4'd5, 16'h0777, 16'd5000, 16'd18, 10, 1'b0, 1'b1);
    expect_frame(0, 10, 10'h100);
    send(0, -1);
    idle(6);
    chk("t6_drop", {16'd0, drop8}, 32'd3);
    chk("t6_bytenum", {16'd0, bn8}, 32'd10);
    chk("t6_srcport", {16'd0, sp8}, 32'h0777);
    chk("t6_q_empty", q8.size(), 32'd0);

    // broadcast accepted, foreign unicast MAC dropped
    build(48'hFFFF_FFFF_FFFF, 4'd5, 16'h1111, 16'd5000, 16'd12, 4, 1'b0, 1'b1);
    expect_frame(0, 4, 10'h100);
    send(0, -1);
    idle(6);
    chk("t7_bcast_bytenum", {16'd0, bn8}, 32'd4);
    chk("t7_bcast_drop", {16'd0, drop8}, 32'd3);
    build(48'h00_11_22_33_44_56, 4'd5, 16'h1111, 16'd5000, 16'd12, 4, 1'b0, 1'b1);
    send(0, -1);
    idle(6);
    chk("t7_mac_drop", {16'd0, drop8}, 32'd4);
    chk("t7_q_empty", q8.size(), 32'd0);

    // reset in the middle of the MAC header; rest of that frame is ignored
    build(MAC, 4'd5, 16'h1234, 16'd5000, 16'd30, 22, 1'b0, 1'b1);
    send(0, 20);
    idle(6);
    chk("t8_drop_after", {16'd0, drop8}, 32'd0);
    chk("t8_q_empty", q8.size(), 32'd0);
    build(MAC, 4'd5, 16'h0ABC, 16'd5000, 16'd14, 6, 1'b0, 1'b1);
    expect_frame(0, 6, 10'h100);
    send(0, -1);
    idle(6);
    chk("t8_bytenum", {16'd0, bn8}, 32'd6);
    chk("t8_srcport", {16'd0, sp8}, 32'h0ABC);
    chk("t8_drop", {16'd0, drop8}, 32'd0);
    chk("t8_q_empty", q8.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
